// File: rtl/dcache_wt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_wt_pkg
// Description : Shared geometry and FSM state encoding for the write-through
//               direct-mapped data cache (dcache_wt, dcache_array).
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_wt_pkg;

    localparam int INDEX_W = 6;
    localparam int TAG_W   = 10;
    localparam int WORD_W  = 32;
    localparam int ADDR_W  = INDEX_W + TAG_W;
    localparam int LINES   = 1 << INDEX_W;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RD_MISS = 2'd1;
    localparam state_t ST_WR_MEM  = 2'd2;
    localparam state_t ST_RESP    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// Module      : dcache_array
// Description : Data, tag and valid storage for the direct-mapped cache.
//               One synchronous write port (writes data + tag and sets valid),
//               one asynchronous read port. Only valid bits are reset.
// Ports       : clk, reset     - clock / synchronous active-high reset
//               we, wr_*       - write port (index, tag, data)
//               rd_index       - lookup index
//               rd_valid/tag/data - lookup result (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_array
    import dcache_wt_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [WORD_W-1:0]  wr_data,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [WORD_W-1:0]  rd_data
);

    logic [WORD_W-1:0] r_data [LINES];
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINES-1:0]  r_valid;

    // Data and tag are deliberately left unreset; valid gates their use.
    always_ff @(posedge clk) begin
        if (we) begin
            r_data[wr_index] <= wr_data;
            r_tag[wr_index]  <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (we) begin
            r_valid[wr_index] <= 1'b1;
        end
    end

    assign rd_valid = r_valid[rd_index];
    assign rd_tag   = r_tag[rd_index];
    assign rd_data  = r_data[rd_index];

endmodule
`default_nettype wire

// File: rtl/dcache_wt.sv
`default_nettype none
// ============================================================================
// Module      : dcache_wt
// Description : 64-line x 1-word direct-mapped data cache, write-through,
//               no-write-allocate. Load hits complete in the request cycle;
//               misses and all stores go to backing memory over a
//               req/ack handshake with registered request outputs.
// Ports       : clk, reset                 - clock / sync active-high reset
//               cpu_rd, cpu_wr, cpu_addr,
//               cpu_wdata                  - CPU request (held until ready)
//               cpu_rdata, cpu_ready       - CPU response
//               mem_req, mem_we, mem_addr,
//               mem_wdata                  - memory request (registered)
//               mem_ack, mem_rdata         - memory completion
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_wt
    import dcache_wt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata
);

    state_t             r_state;
    state_t             w_next_state;
    logic [WORD_W-1:0]  r_resp;

    logic [INDEX_W-1:0] w_lu_index;
    logic [TAG_W-1:0]   w_lu_tag_in;
    logic               w_lu_valid;
    logic [TAG_W-1:0]   w_lu_tag;
    logic [WORD_W-1:0]  w_lu_data;
    logic               w_hit;

    logic               w_arr_we;
    logic [INDEX_W-1:0] w_arr_index;
    logic [TAG_W-1:0]   w_arr_tag;
    logic [WORD_W-1:0]  w_arr_data;

    assign w_lu_index  = cpu_addr[INDEX_W-1:0];
    assign w_lu_tag_in = cpu_addr[ADDR_W-1:INDEX_W];
    assign w_hit       = w_lu_valid && (w_lu_tag == w_lu_tag_in);

    dcache_array u_array (
        .clk      (clk),
        .reset    (reset),
        .we       (w_arr_we),
        .wr_index (w_arr_index),
        .wr_tag   (w_arr_tag),
        .wr_data  (w_arr_data),
        .rd_index (w_lu_index),
        .rd_valid (w_lu_valid),
        .rd_tag   (w_lu_tag),
        .rd_data  (w_lu_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cpu_wr) begin
                    w_next_state = ST_WR_MEM;
                end else if (cpu_rd && !w_hit) begin
                    w_next_state = ST_RD_MISS;
                end
            end
            ST_RD_MISS: if (mem_ack) w_next_state = ST_RESP;
            ST_WR_MEM:  if (mem_ack) w_next_state = ST_IDLE;
            ST_RESP:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Output / array-write logic. The fill takes index and tag from the
    // registered mem_addr so it does not depend on cpu_addr during the miss.
    always_comb begin
        cpu_ready   = 1'b0;
        cpu_rdata   = w_lu_data;
        w_arr_we    = 1'b0;
        w_arr_index = w_lu_index;
        w_arr_tag   = w_lu_tag_in;
        w_arr_data  = cpu_wdata;
        case (r_state)
            ST_IDLE: begin
                cpu_ready = cpu_rd && w_hit;
                w_arr_we  = cpu_wr && w_hit;
            end
            ST_RD_MISS: begin
                if (mem_ack) begin
                    w_arr_we    = 1'b1;
                    w_arr_index = mem_addr[INDEX_W-1:0];
                    w_arr_tag   = mem_addr[ADDR_W-1:INDEX_W];
                    w_arr_data  = mem_rdata;
                end
            end
            ST_WR_MEM: cpu_ready = mem_ack;
            ST_RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = r_resp;
            end
            default: cpu_ready = 1'b0;
        endcase
        if (reset) begin
            cpu_ready = 1'b0;
            w_arr_we  = 1'b0;
        end
    end

    // Registered memory request and response register
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r_resp    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_wr) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                    end else if (cpu_rd && !w_hit) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= cpu_addr;
                    end
                end
                ST_RD_MISS: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        r_resp  <= mem_rdata;
                    end
                end
                ST_WR_MEM: if (mem_ack) mem_req <= 1'b0;
                default: ;
            endcase
        end
    end

    // A pending request must be held until cpu_ready.
    a_rd_held: assert property (@(posedge clk) disable iff (reset)
        (r_state == ST_RD_MISS || r_state == ST_RESP) |-> cpu_rd);
    a_wr_held: assert property (@(posedge clk) disable iff (reset)
        (r_state == ST_WR_MEM) |-> cpu_wr);

endmodule
`default_nettype wire

// File: doc/dcache_wt.md
DCACHE_WT -- requirements
Module: dcache_wt

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high; clock clk.
REQ-003 cpu_rd  input  1  load request from the memory stage, held until cpu_ready.
REQ-004 cpu_wr  input  1  store request, held until cpu_ready; cpu_rd and cpu_wr never both 1.
REQ-005 cpu_addr  input  16  word address (byte address bits 17:2).
REQ-006 cpu_wdata  input  32  store data.
REQ-007 cpu_rdata  output  32  load data, valid when cpu_ready=1 with cpu_rd=1.
REQ-008 cpu_ready  output  1  request completes this cycle; pipeline stalls while a request is pending and cpu_ready=0.
REQ-009 mem_req  output  1  backing-memory request, held until mem_ack.
REQ-010 mem_we  output  1  1=write, 0=read; stable while mem_req=1.
REQ-011 mem_addr  output  16  word address; stable while mem_req=1.
REQ-012 mem_wdata  output  32  write data; stable while mem_req=1.
REQ-013 mem_ack  input  1  one-cycle completion pulse; ignored when mem_req=0.
REQ-014 mem_rdata  input  32  read data, valid in the mem_ack cycle.

Function
REQ-015 Organisation: direct-mapped, 64 lines x 1 word; index=cpu_addr[5:0], tag=cpu_addr[15:6] (10 bits), one valid bit per line.
REQ-016 Hit = valid[index] and tag match, evaluated combinationally in the same cycle.
REQ-017 Policy: write-through, no-write-allocate; write hit updates the line and memory; write miss updates memory only.
REQ-018 FSM states: IDLE, RD_MISS, WR_MEM, RESP.
REQ-019 IDLE, cpu_rd and hit: cpu_ready=1 and cpu_rdata=line data in the same cycle (zero-wait load); stay in IDLE.
REQ-020 IDLE, cpu_rd and miss: go to RD_MISS; mem_req=1, mem_we=0, mem_addr=cpu_addr.
REQ-021 RD_MISS, mem_ack: write mem_rdata into line data, write tag, set valid, latch mem_rdata into the response register, then go to RESP.
REQ-022 RESP: cpu_ready=1 for exactly one cycle, cpu_rdata=response register; return to IDLE; no lookup is performed.
REQ-023 IDLE, cpu_wr: on a hit, update line data at the edge; in every case go to WR_MEM with mem_req=1, mem_we=1, mem_wdata=cpu_wdata.
REQ-024 WR_MEM, mem_ack: cpu_ready=1 in the ack cycle; return to IDLE.
REQ-025 Minimum latencies: load hit 0 stall cycles; load miss N+1 stall cycles; store N stall cycles, where N = request-to-ack cycles.
REQ-026 mem_req, mem_we, mem_addr and mem_wdata are registered outputs; they do not change between request assertion and mem_ack.
REQ-027 A request that drops before cpu_ready is not supported; behaviour is undefined and an assertion is required.
REQ-028 mem_ack in IDLE or RESP is ignored and does not change state.
REQ-029 A load to the same address in the cycle after RESP hits and returns the filled data.
REQ-030 A load that hits the line just written in the previous cycle returns the new store data.
REQ-031 cpu_ready=0 in RD_MISS, in WR_MEM without mem_ack, and in IDLE with no request.

Reset
REQ-032 Reset forces IDLE and clears every valid bit in one cycle; data and tag arrays are not reset.
REQ-033 Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_ready=0, response register=0.
REQ-034 Reset asserted mid-miss or mid-write abandons the transaction; the late mem_ack is ignored per REQ-028.

Structure
REQ-035 Shared package holds the FSM state encoding, INDEX_W=6, TAG_W=10, and WORD_W=32.
REQ-036 A single sub-module dcache_array holds the data, tag and valid storage, with one synchronous write port and an asynchronous read port.
REQ-037 Controller RTL is 120-400 lines in total.

Verification
REQ-038 After reset, load 0x0010 -> miss; mem_req with addr 0x0010; ack with 0xCAFE0001 two cycles later -> cpu_ready in RESP with 0xCAFE0001; repeat load -> 0-wait hit with the same data.
REQ-039 Store 0x0010 <- 0x12345678 (hit) -> mem write to 0x0010; cpu_ready on ack; next load 0x0010 -> hit returning 0x12345678.
REQ-040 Store to 0x0450 (miss) -> mem write only; next load 0x0450 -> miss (no allocate).
REQ-041 Fill 0x0010, then load 0x0050 (same index, tag 1) -> miss and line replaced; load 0x0010 -> miss.
REQ-042 Assert reset in RD_MISS, then pulse mem_ack -> FSM stays IDLE, no cpu_ready; load 0x0010 afterwards -> miss.
REQ-043 Hold mem_ack low for 20 cycles during a miss -> mem_req, mem_addr and cpu_ready=0 stay stable for all 20 cycles.
